// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush generation for load-use,
// EX redirects and memory wait states, plus stall/flush performance counters.
module pipe_hazard_ctrl #(
   parameter int unsigned DMEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_is_load,
   input  logic        ex_redirect,
   input  logic        imem_ready,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        if_id_flush,
   output logic        id_ex_stall,
   output logic        id_ex_flush,
   output logic        ex_mem_stall,
   output logic        mem_wb_flush,
   output logic        dmem_timeout,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
);

   typedef enum logic {RUN, DWAIT} state_t;

   localparam logic [15:0] TIMEOUT_VAL = 16'(DMEM_TIMEOUT);

   state_t      state, state_next;
   logic [15:0] wait_cnt, wait_cnt_next;
   logic        kill_pending, kill_next;
   logic        timeout_fired, timeout_fired_next, timeout_next;
   logic        dwait, lu;

   assign dwait = dmem_req & ~dmem_ready;
   assign lu    = ex_is_load & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

   // Priority chain: data wait freezes everything, so a redirect in EX is re-presented later.
   always_comb begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
      mem_wb_flush = 1'b0;
      kill_next    = kill_pending;
      if (dwait) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         kill_next   = kill_pending | ~imem_ready;
      end else if (lu) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end else if (kill_pending) begin
         pc_stall    = 1'b1;
         if_id_flush = 1'b1;
         if (imem_ready)
            kill_next = 1'b0;
      end else if (!imem_ready) begin
         pc_stall    = 1'b1;
         if_id_flush = 1'b1;
      end
   end

   // Wait counter saturates at the timeout; the fired flag keeps the pulse to one cycle.
   always_comb begin
      state_next         = state;
      wait_cnt_next      = wait_cnt;
      timeout_fired_next = timeout_fired;
      timeout_next       = 1'b0;
      case (state)
         RUN: begin
            timeout_fired_next = 1'b0;
            if (dwait) begin
               state_next    = DWAIT;
               wait_cnt_next = 16'd1;
            end
         end
         DWAIT: begin
            if (!dwait) begin
               state_next         = RUN;
               wait_cnt_next      = 16'd0;
               timeout_fired_next = 1'b0;
            end else begin
               if ((wait_cnt == TIMEOUT_VAL) && !timeout_fired) begin
                  timeout_next       = 1'b1;
                  timeout_fired_next = 1'b1;
               end
               if (wait_cnt != TIMEOUT_VAL)
                  wait_cnt_next = wait_cnt + 16'd1;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= RUN;
         wait_cnt      <= 16'd0;
         kill_pending  <= 1'b0;
         timeout_fired <= 1'b0;
         dmem_timeout  <= 1'b0;
         stall_cycles  <= 32'd0;
         flush_events  <= 32'd0;
      end else begin
         state         <= state_next;
         wait_cnt      <= wait_cnt_next;
         kill_pending  <= kill_next;
         timeout_fired <= timeout_fired_next;
         dmem_timeout  <= timeout_next;
         stall_cycles  <= stall_cycles + {31'd0, pc_stall};
         flush_events  <= flush_events + {31'd0, id_ex_flush};
      end
   end

   // Stall must dominate flush inside every pipeline register.
   assert property (@(posedge clk) !(if_id_stall && if_id_flush));
   assert property (@(posedge clk) !(id_ex_stall && id_ex_flush));

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller that generates the per-stage stall and flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It resolves load-use hazards, EX-stage control-flow redirects, and instruction/data memory wait states. It tracks in-flight wrong-path fetches across a redirect and keeps stall and flush performance counters. It sits beside the datapath and drives the `stall`/`flush` inputs of every pipeline register.

## Interface
- `DMEM_TIMEOUT`, default 255: data-memory wait cycles before `dmem_timeout` pulses. Legal range is 1..65535.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: synchronous reset, active-high.
- `id_rs1`, `id_rs2` input, 5 bits each: decode-stage source register indices.
- `id_use_rs1`, `id_use_rs2` input, 1 bit each: the decode instruction actually reads that source.
- `ex_rd` input, 5 bits: EX-stage destination register.
- `ex_is_load` input, 1 bit: the EX instruction is a valid load.
- `ex_redirect` input, 1 bit: taken branch, jump or trap in EX. The PC loads the target this cycle unless `pc_stall` is high.
- `imem_ready` input, 1 bit: the instruction fetch response is valid this cycle.
- `dmem_req` input, 1 bit: the MEM stage has an active access.
- `dmem_ready` input, 1 bit: the data access completes this cycle.
- `pc_stall` output, 1 bit: hold the PC.
- `if_id_stall`, `if_id_flush` output, 1 bit each: controls for the IF/ID register.
- `id_ex_stall`, `id_ex_flush` output, 1 bit each: controls for the ID/EX register.
- `ex_mem_stall` output, 1 bit: hold the EX/MEM register.
- `mem_wb_flush` output, 1 bit: insert a bubble into WB.
- `dmem_timeout` output, 1 bit: single-cycle pulse.
- `stall_cycles` output, 32 bits: count of cycles with `pc_stall` high.
- `flush_events` output, 32 bits: count of cycles with `id_ex_flush` high.

## Operation
Internal signals:
- `dwait = dmem_req & ~dmem_ready`.
- `lu = ex_is_load & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))`.

Priority is evaluated each cycle; the first matching row drives the outputs:
1. **dwait**: assert `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` and `mem_wb_flush`. Any `ex_redirect` is ignored this cycle; EX is frozen, so the redirect is re-presented later.
2. **ex_redirect**: assert `if_id_flush` and `id_ex_flush`. `pc_stall` stays low so the target loads. If `imem_ready` is 0, set `kill_pending`.
3. **lu**: assert `pc_stall` and `if_id_stall`, plus `id_ex_flush` to insert one bubble.
4. **kill_pending**: assert `pc_stall` and `if_id_flush`. When `imem_ready` is 1 this cycle, clear `kill_pending`; the stale response is discarded and the target fetch issues next cycle.
5. **~imem_ready**: assert `pc_stall` and `if_id_flush` (bubble into decode).
6. **Otherwise**: all control outputs are 0.

Invariants:
- Stall dominates flush inside each pipeline register, so the controller never asserts stall and flush together on the same register. This is an assertion target.
- A redirect while `kill_pending` is already set leaves it set.

Data-wait FSM, states RUN and DWAIT:
- RUN goes to DWAIT when `dwait`; the wait counter loads 1.
- In DWAIT, the counter increments each cycle while `dwait` holds.
- When the counter equals `DMEM_TIMEOUT`, `dmem_timeout` pulses for exactly one cycle. The counter then saturates and the stall continues.
- DWAIT returns to RUN on the cycle `dmem_ready` is 1; the counter clears.

Counters:
- `stall_cycles` and `flush_events` are 32-bit, free-running, and wrap from 0xFFFFFFFF to 0.
- Each increments on the clock edge following a qualifying cycle.

## Timing
- All control outputs are combinational from the current inputs, `kill_pending` and the FSM state. There is no added latency.
- `kill_pending`, the FSM state, the wait counter, `dmem_timeout` and the performance counters are registered. `dmem_timeout` is a registered pulse, high the cycle after the counter reaches `DMEM_TIMEOUT`.
- Reset values:
  - FSM state RUN, wait counter 0.
  - `kill_pending` 0, `dmem_timeout` 0.
  - `stall_cycles` and `flush_events` 0.
  - Control outputs take the values implied by the inputs while `rst` is high, but all registered state is held at its reset value.
- Reset mid-wait: the FSM returns to RUN immediately, no timeout pulse is issued, and `kill_pending` clears.
- Load-use costs exactly one bubble. A load followed by a dependent instruction sees `lu` for one cycle.
- A redirect with `imem_ready=1` costs 2 bubbles. Each cycle of `imem_ready=0` after a redirect adds one further kill cycle.

## Test plan
- **Load-use:** load x5 in EX, decode reads rs1=x5 -> one cycle with `pc_stall=1`, `if_id_stall=1`, `id_ex_flush=1`; next cycle all control outputs are 0. `stall_cycles` increments by 1.
- **x0 and unused operands:** load with rd=0, or rs2 matches but `id_use_rs2=0` -> no stall.
- **Redirect during imem wait:** `ex_redirect=1` with `imem_ready=0`, then `imem_ready=0` for 2 cycles, then 1 -> flush on the redirect cycle, then 3 cycles of `pc_stall=1`/`if_id_flush=1`. `kill_pending` is 0 after the ready cycle.
- **Data wait:** `dmem_req=1`, `dmem_ready=0` for 4 cycles with `ex_redirect=1` held -> 4 cycles with all stalls and `mem_wb_flush` high and no flush on IF/ID or ID/EX. The redirect flush follows on the `dmem_ready` cycle.
- **Timeout:** `DMEM_TIMEOUT=3`, ready withheld 10 cycles -> exactly one `dmem_timeout` pulse, and the stall persists until ready.
- **Counter wrap and reset:** preload counters near wrap through 0xFFFFFFFF stall cycles (forced) -> wraps to 0. Assert `rst` mid-DWAIT -> FSM in RUN and counters 0 on the next cycle.
